// File: rtl/lsu_pkg.sv
// Shared definitions for the sub-word load/store unit.
// funct3 encodings, FSM state type and the store lane merge.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } lsu_state_t;

  function automatic logic [31:0] merge_lane(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic        half,
    input logic [1:0]  sel
  );
    logic [31:0] m;
    m = word;
    if (half) begin
      if (sel[1]) m[31:16] = wdata[15:0];
      else        m[15:0]  = wdata[15:0];
    end else begin
      unique case (sel)
        2'd0: m[7:0]   = wdata[7:0];
        2'd1: m[15:8]  = wdata[7:0];
        2'd2: m[23:16] = wdata[7:0];
        2'd3: m[31:24] = wdata[7:0];
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane extraction with sign or zero extension.
// Little-endian; unknown funct3 yields zero.
import lsu_pkg::*;

module lsu_load_ext (
  input  logic [31:0] dout,
  input  logic [2:0]  funct3,
  input  logic [1:0]  sel,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = dout[7:0];
    unique case (sel)
      2'd0: lane_b = dout[7:0];
      2'd1: lane_b = dout[15:8];
      2'd2: lane_b = dout[23:16];
      2'd3: lane_b = dout[31:24];
    endcase
    lane_h = sel[1] ? dout[31:16] : dout[15:0];
  end

  always_comb begin
    rdata = 32'h0;
    case (funct3)
      F3_LB:   rdata = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  rdata = {24'h0, lane_b};
      F3_LH:   rdata = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  rdata = {16'h0, lane_h};
      F3_LW:   rdata = dout;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit: word-wide memory, byte/half via
// a two-cycle read-modify-write that stalls the core.
import lsu_pkg::*;

module lsu_subword #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  output logic              dmem_read,
  output logic              dmem_write,
  input  logic [31:0]       dmem_dout
);

  lsu_state_t  state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] ld_data;
  logic        is_half, is_word;
  logic        bad_f3, fault;

  lsu_load_ext u_ext (
    .dout   (dmem_dout),
    .funct3 (req_funct3),
    .sel    (req_addr[1:0]),
    .rdata  (ld_data)
  );

  assign dmem_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // Stores have no unsigned forms, so 1xx stores fault too.
  always_comb begin
    is_half = (req_funct3[1:0] == 2'b01);
    is_word = (req_funct3 == F3_LW);
    bad_f3  = !(req_funct3 inside {F3_LB, F3_LH, F3_LW,
                                   F3_LBU, F3_LHU});
    if (req_we) bad_f3 = bad_f3 | req_funct3[2];
    fault = bad_f3
          | (is_half & req_addr[0])
          | (is_word & (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    merge_d    = merge_q;
    stall      = 1'b0;
    done       = 1'b0;
    misalign   = 1'b0;
    rdata      = 32'h0;
    dmem_din   = 32'h0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (fault) begin
            misalign = 1'b1;
            done     = 1'b1;
          end else if (!req_we) begin
            dmem_read = 1'b1;
            done      = 1'b1;
            rdata     = ld_data;
          end else if (is_word) begin
            dmem_write = 1'b1;
            dmem_din   = req_wdata;
            done       = 1'b1;
          end else begin
            dmem_read = 1'b1;
            stall     = 1'b1;
            merge_d   = merge_lane(dmem_dout, req_wdata,
                                   is_half, req_addr[1:0]);
            state_d   = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dmem_write = 1'b1;
        dmem_din   = merge_q;
        done       = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a word memory model.
// Status vector order: {stall,done,misalign,read,write}.
module tb_lsu_subword;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          req_valid;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          stall, done, misalign;
  logic [31:0]   rdata;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_din;
  logic          dmem_read, dmem_write;
  logic [31:0]   dmem_dout;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_subword #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .misalign   (misalign),
    .rdata      (rdata),
    .dmem_addr  (dmem_addr),
    .dmem_din   (dmem_din),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_dout  (dmem_dout)
  );

  assign dmem_dout = mem[dmem_addr[9:2]];

  always @(posedge clk) begin
    if (dmem_write) mem[dmem_addr[9:2]] <= dmem_din;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  function automatic logic [4:0] st();
    return {stall, done, misalign, dmem_read, dmem_write};
  endfunction

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic release_req();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = 32'h0;
  endtask

  task automatic preload(input logic [7:0] idx,
                         input logic [31:0] v);
    @(negedge clk);
    release_req();
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    release_req();
    #3;
    n_chk++;
    if ({st(), rdata, dmem_din} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_outs got st=%b rd=%h din=%h exp 0",
               st(), rdata, dmem_din);
    end
    @(negedge clk);
    reset_b = 1'b1;
    drive(1'b1, F3_LW, 10'h3A7, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    #1;
    n_chk++;
    if ({st(), rdata, dmem_din} !== 69'h0) begin
      n_fail++;
      $display("FAIL idle_outs got st=%b rd=%h din=%h exp 0",
               st(), rdata, dmem_din);
    end
    n_chk++;
    if (dmem_addr !== 10'h3A4) begin
      n_fail++;
      $display("FAIL idle_addr got %h exp 3a4", dmem_addr);
    end
    @(negedge clk);
    release_req();
  endtask

  task automatic test_load_ext();
    logic [2:0]    f3 [7];
    logic [AW-1:0] ad [7];
    logic [31:0]   ex [7];
    f3 = '{F3_LB, F3_LBU, F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
    ad = '{10'h011, 10'h011, 10'h012, 10'h012,
           10'h012, 10'h012, 10'h010};
    ex = '{32'h0000_007F, 32'h0000_007F, 32'hFFFF_FFF1,
           32'h0000_00F1, 32'hFFFF_80F1, 32'h0000_80F1,
           32'h80F1_7F01};
    preload(8'h04, 32'h80F1_7F01);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b0, f3[i], ad[i], 32'h0);
      #1;
      n_chk++;
      if (rdata !== ex[i] || st() !== 5'b01010) begin
        n_fail++;
        $display("FAIL load_%0d got rd=%h st=%b exp rd=%h st=01010",
                 i, rdata, st(), ex[i]);
      end
    end
    @(negedge clk);
    release_req();
  endtask

  task automatic test_sb_rmw();
    preload(8'h08, 32'h1122_3344);
    @(negedge clk);
    drive(1'b1, F3_LB, 10'h022, 32'h0000_00AB);
    #1;
    n_chk++;
    if (st() !== 5'b10010) begin
      n_fail++;
      $display("FAIL sb_cyc1 got st=%b exp 10010", st());
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (st() !== 5'b01001 || dmem_din !== 32'h11AB_3344) begin
      n_fail++;
      $display("FAIL sb_cyc2 got st=%b din=%h exp 01001 11ab3344",
               st(), dmem_din);
    end
    @(negedge clk);
    drive(1'b0, F3_LW, 10'h020, 32'h0);
    #1;
    n_chk++;
    if (rdata !== 32'h11AB_3344 || st() !== 5'b01010) begin
      n_fail++;
      $display("FAIL sb_readback got rd=%h st=%b exp 11ab3344",
               rdata, st());
    end
    @(negedge clk);
    release_req();
  endtask

  task automatic test_sh_sw();
    preload(8'h0C, 32'hFFFF_FFFF);
    preload(8'h0D, 32'h0000_0000);
    @(negedge clk);
    drive(1'b1, F3_LH, 10'h032, 32'h0000_BEEF);
    #1;
    n_chk++;
    if (st() !== 5'b10010) begin
      n_fail++;
      $display("FAIL sh_cyc1 got st=%b exp 10010", st());
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (st() !== 5'b01001 || dmem_din !== 32'hBEEF_FFFF) begin
      n_fail++;
      $display("FAIL sh_cyc2 got st=%b din=%h exp 01001 beefffff",
               st(), dmem_din);
    end
    @(negedge clk);
    drive(1'b1, F3_LW, 10'h034, 32'hCAFE_F00D);
    #1;
    n_chk++;
    if (st() !== 5'b01001 || dmem_din !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL sw got st=%b din=%h exp 01001 cafef00d",
               st(), dmem_din);
    end
    @(negedge clk);
    release_req();
    #1;
    n_chk++;
    if (mem[12] !== 32'hBEEF_FFFF || mem[13] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL sh_sw_mem got %h %h exp beefffff cafef00d",
               mem[12], mem[13]);
    end
  endtask

  task automatic test_misalign();
    logic          we [4];
    logic [2:0]    f3 [4];
    logic [AW-1:0] ad [4];
    we = '{1'b0, 1'b0, 1'b1, 1'b0};
    f3 = '{F3_LW, F3_LH, F3_LH, 3'b011};
    ad = '{10'h041, 10'h043, 10'h045, 10'h044};
    preload(8'h11, 32'h5A5A_A5A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(we[i], f3[i], ad[i], 32'h1234_5678);
      #1;
      n_chk++;
      if (st() !== 5'b01100 || rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL misalign_%0d got st=%b rd=%h exp 01100 0",
                 i, st(), rdata);
      end
    end
    @(negedge clk);
    release_req();
    #1;
    n_chk++;
    if (mem[17] !== 32'h5A5A_A5A5) begin
      n_fail++;
      $display("FAIL misalign_mem got %h exp 5a5aa5a5", mem[17]);
    end
  endtask

  task automatic test_reset_rmw();
    preload(8'h14, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b1, F3_LB, 10'h050, 32'h0000_0077);
    @(posedge clk);
    #1;
    n_chk++;
    if (st() !== 5'b01001) begin
      n_fail++;
      $display("FAIL rst_rmw_state got st=%b exp 01001", st());
    end
    #1;
    reset_b = 1'b0;
    release_req();
    #1;
    n_chk++;
    if (st() !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_rmw_outs got st=%b exp 00000", st());
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (mem[20] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rst_rmw_mem got %h exp deadbeef", mem[20]);
    end
    reset_b = 1'b1;
    #1;
    n_chk++;
    if (st() !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_rmw_after got st=%b exp 00000", st());
    end
  endtask

  task automatic test_back_to_back();
    preload(8'h18, 32'h0000_0000);
    @(negedge clk);
    drive(1'b1, F3_LB, 10'h060, 32'h0000_0011);
    #1;
    n_chk++;
    if (st() !== 5'b10010) begin
      n_fail++;
      $display("FAIL b2b_c1 got st=%b exp 10010", st());
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (st() !== 5'b01001 || dmem_din !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL b2b_c2 got st=%b din=%h exp 01001 00000011",
               st(), dmem_din);
    end
    @(negedge clk);
    drive(1'b1, F3_LB, 10'h061, 32'h0000_0022);
    #1;
    n_chk++;
    if (st() !== 5'b10010) begin
      n_fail++;
      $display("FAIL b2b_c3 got st=%b exp 10010", st());
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (st() !== 5'b01001 || dmem_din !== 32'h0000_2211) begin
      n_fail++;
      $display("FAIL b2b_c4 got st=%b din=%h exp 01001 00002211",
               st(), dmem_din);
    end
    @(negedge clk);
    release_req();
    #1;
    n_chk++;
    if (mem[24] !== 32'h0000_2211 || st() !== 5'b00000) begin
      n_fail++;
      $display("FAIL b2b_mem got %h st=%b exp 00002211 00000",
               mem[24], st());
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_sb_rmw();
    test_sh_sw();
    test_misalign();
    test_reset_rmw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
